// File: rtl/lfsr_stream_if.sv
// rtl/lfsr_stream_if.sv - control/status bundle for the lfsr_stream pseudo-random source
interface lfsr_stream_if #(
  parameter int WIDTH = 13,
  parameter int CNT_W = 13
);
  logic             ce;
  logic             start;
  logic             seed_we;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] lfsr;
  logic             lfsr_valid;
  logic             lfsr_busy;
  logic             lfsr_done;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output ce, start, seed_we, seed_in,
    input  lfsr, lfsr_valid, lfsr_busy, lfsr_done, step_cnt
  );

  modport slave (
    input  ce, start, seed_we, seed_in,
    output lfsr, lfsr_valid, lfsr_busy, lfsr_done, step_cnt
  );
endinterface

// File: rtl/lfsr_stream.sv
// rtl/lfsr_stream.sv - Fibonacci LFSR source running RUN_LEN steps per request (optional LFSR_ZERO_GUARD_EN)
module lfsr_stream #(
  parameter int               WIDTH   = 13,
  parameter logic [WIDTH-1:0] TAPS    = 13'h1C80,
  parameter logic [WIDTH-1:0] SEED    = 1,
  parameter int               RUN_LEN = 8191,
  parameter int               CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_stream_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_valid_nxt;
  logic             w_fb;
  logic [WIDTH-1:0] w_lfsr_step;
  logic [WIDTH-1:0] w_seed_load;
  logic             w_last_step;

  assign w_fb        = ^(r_lfsr & TAPS);
  assign w_last_step = (r_cnt == CNT_W'(RUN_LEN - 1));

`ifdef LFSR_ZERO_GUARD_EN
  // An all-zero state or seed is replaced by SEED so the register cannot lock up.
  assign w_lfsr_step = (r_lfsr == '0) ? SEED : {r_lfsr[WIDTH-2:0], w_fb};
  assign w_seed_load = (bus.seed_in == '0) ? SEED : bus.seed_in;
`else
  assign w_lfsr_step = {r_lfsr[WIDTH-2:0], w_fb};
  assign w_seed_load = bus.seed_in;
`endif

  // Next-state and datapath decode; DONE always returns to IDLE regardless of ce.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ce) begin
          if (bus.seed_we) begin
            w_lfsr_nxt = w_seed_load;
          end
          if (bus.start) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_RUN: begin
        if (bus.ce) begin
          w_lfsr_nxt  = w_lfsr_step;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_valid_nxt = 1'b1;
          if (w_last_step) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; rst wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.lfsr       = r_lfsr;
  assign bus.lfsr_valid = r_valid;
  assign bus.lfsr_busy  = (r_state == S_RUN);
  assign bus.lfsr_done  = (r_state == S_DONE);
  assign bus.step_cnt   = r_cnt;

endmodule

// File: tb/tb_lfsr_stream.sv
// tb/tb_lfsr_stream.sv - randomized self-checking bench for lfsr_stream against a parity-rule model
module tb_lfsr_stream;

`ifdef LFSR_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [12:0] TAPS_M = 13'h1C80;
  localparam logic [12:0] SEED_M = 13'h0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lfsr_stream_if #(.WIDTH(13), .CNT_W(13)) if1 ();
  lfsr_stream_if #(.WIDTH(13), .CNT_W(3))  if4 ();

  lfsr_stream u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  lfsr_stream #(.RUN_LEN(4), .CNT_W(3)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: feedback is the parity of the tapped bits, shifted in at the LSB.
  function automatic logic [12:0] m_next(input logic [12:0] s);
    int ones;
    if (GUARD && s == 13'h0) return SEED_M;
    ones = $countones(s & TAPS_M);
    return {s[11:0], (ones % 2) == 1};
  endfunction

  function automatic logic [12:0] m_load(input logic [12:0] s);
    if (GUARD && s == 13'h0) return SEED_M;
    return s;
  endfunction

  // One RUN_LEN=4 run with seed load; ce for cycle i after start is ce_bits[i].
  task automatic run4(input logic [12:0] seed, input logic [31:0] ce_bits, input string tag);
    logic [12:0] m;
    int          cnt;
    logic        ce_now;
    m   = m_load(seed);
    cnt = 0;
    if4.ce      = 1'b1;
    if4.seed_in = seed;
    if4.seed_we = 1'b1;
    if4.start   = 1'b1;
    tick();
    if4.seed_we = 1'b0;
    if4.start   = 1'b0;
    check({tag, "_e0_lfsr"}, if4.lfsr, m);
    check({tag, "_e0_busy"}, if4.lfsr_busy, 1);
    check({tag, "_e0_cnt"},  if4.step_cnt, 0);
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      ce_now = (i < 32) ? ce_bits[i] : 1'b1;
      if4.ce = ce_now;
      tick();
      if (ce_now) begin
        m = m_next(m);
        cnt++;
      end
      check($sformatf("%s_c%0d_lfsr", tag, i),  if4.lfsr, m);
      check($sformatf("%s_c%0d_cnt", tag, i),   if4.step_cnt, cnt);
      check($sformatf("%s_c%0d_valid", tag, i), if4.lfsr_valid, ce_now);
      check($sformatf("%s_c%0d_done", tag, i),  if4.lfsr_done, cnt == 4);
      check($sformatf("%s_c%0d_busy", tag, i),  if4.lfsr_busy, cnt < 4);
    end
    check({tag, "_budget"}, cnt, 4);
    if4.ce = 1'($urandom_range(0, 1));
    tick();
    check({tag, "_post_done"}, if4.lfsr_done, 0);
    check({tag, "_post_busy"}, if4.lfsr_busy, 0);
    check({tag, "_post_cnt"},  if4.step_cnt, 4);
    check({tag, "_post_lfsr"}, if4.lfsr, m);
    if4.ce = 1'b1;
  endtask

  initial begin
    logic [12:0] m;
    int          done_cycles;
    int          seen_seed;

    if1.ce = 1'b1; if1.start = 1'b0; if1.seed_we = 1'b0; if1.seed_in = '0;
    if4.ce = 1'b1; if4.start = 1'b0; if4.seed_we = 1'b0; if4.seed_in = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_lfsr",  if1.lfsr, SEED_M);
    check("rst_cnt",   if1.step_cnt, 0);
    check("rst_valid", if1.lfsr_valid, 0);
    check("rst_busy",  if1.lfsr_busy, 0);
    check("rst_done",  if1.lfsr_done, 0);
    check("rst4_lfsr", if4.lfsr, SEED_M);
    rst = 1'b0;
    tick();

    // Full-length run from reset seed
    m = SEED_M;
    done_cycles = 0;
    seen_seed = 0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("full_e0_busy", if1.lfsr_busy, 1);
    check("full_e0_lfsr", if1.lfsr, SEED_M);
    check("full_e0_valid", if1.lfsr_valid, 0);
    for (int k = 1; k <= 8191; k++) begin
      tick();
      m = m_next(m);
      check($sformatf("full_s%0d_lfsr", k),  if1.lfsr, m);
      check($sformatf("full_s%0d_valid", k), if1.lfsr_valid, 1);
      check($sformatf("full_s%0d_busy", k),  if1.lfsr_busy, k < 8191);
      if (k == 7) check("full_s7_const", if1.lfsr, 13'h0080);
      if (k == 8) check("full_s8_const", if1.lfsr, 13'h0101);
      if (if1.lfsr_done) done_cycles++;
      if (k < 8191 && if1.lfsr == 13'h0001) seen_seed++;
    end
    check("full_end_lfsr", if1.lfsr, 13'h0001);
    check("full_end_cnt",  if1.step_cnt, 8191);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (if1.lfsr_done) done_cycles++;
    end
    check("full_done_width", done_cycles, 1);
    check("full_no_early_seed", seen_seed, 0);
    check("full_idle_cnt", if1.step_cnt, 8191);
    check("full_idle_busy", if1.lfsr_busy, 0);

    // Seed load and start in the same cycle, RUN_LEN=4
    run4(13'h0ABC, 32'hFFFF_FFFF, "abc");

    // ce pattern 1,0,1,0 then high
    run4(13'h0ABC, 32'hFFFF_FFF5, "ce1010");

    // Randomized seeds and ce patterns
    for (int r = 0; r < 6; r++) begin
      run4(13'($urandom_range(1, 8191)), $urandom, $sformatf("rnd%0d", r));
    end

    // start/seed_we ignored during RUN, then reset at step 100
    m = SEED_M;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 50 || k == 51) begin
        if1.start   = 1'b1;
        if1.seed_we = 1'b1;
        if1.seed_in = 13'($urandom_range(1, 8191));
      end else begin
        if1.start   = 1'b0;
        if1.seed_we = 1'b0;
      end
      tick();
      m = m_next(m);
      check($sformatf("mid_s%0d_lfsr", k), if1.lfsr, m);
    end
    check("mid_cnt100", if1.step_cnt, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_lfsr", if1.lfsr, 13'h0001);
    check("mid_rst_cnt",  if1.step_cnt, 0);
    check("mid_rst_busy", if1.lfsr_busy, 0);
    check("mid_rst_done", if1.lfsr_done, 0);
    check("mid_rst_valid", if1.lfsr_valid, 0);
    tick();
    check("mid_rst_done2", if1.lfsr_done, 0);

    // Zero seed: guarded build substitutes SEED, plain build locks at zero
    if1.seed_in = 13'h0;
    if1.seed_we = 1'b1;
    tick();
    if1.seed_we = 1'b0;
    m = m_load(13'h0);
    check("zero_load", if1.lfsr, m);
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      m = m_next(m);
      check($sformatf("zero_s%0d_lfsr", k), if1.lfsr, m);
    end
    check("zero_cnt10", if1.step_cnt, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run4(13'h0, 32'hFFFF_FFFF, "zero4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
